dla_psum_accum_ctrl: RTL and testbench
======================================

# dla_psum_accum_ctrl

Sequencer for the DLA 3×3 convolution datapath.
- Takes the three per-row partial sums produced each beat by the row adder stage and sums them.
- Accumulates them across a programmed number of input channels, starting from a per-job bias.
- Applies optional ReLU and saturates to a signed half-word.
- Emits one result per output pixel through a valid/ready handshake.
- Sits between the row-adder stage and the output buffer writer; the DLA top-level CSR block configures and starts it.

## Interface
Parameters:
- `CH_W`, 8 — width of the channel-count field; a value N means N+1 channels.
- `PIX_W`, 16 — width of the pixel-count field; a value N means N pixels (0 allowed).
- `ACC_W`, 32 — internal accumulator width.

Ports:
- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `cfg_start`  in  1  — one-cycle job start; honoured only in IDLE.
- `cfg_num_ch`  in  CH_W  — channels per pixel minus one.
- `cfg_num_pix`  in  PIX_W  — pixels in the job.
- `cfg_bias`  in  `HWORD` signed  — initial accumulator value per pixel.
- `cfg_relu`  in  1  — clamp negative results to 0.
- `in_valid`  in  1  — a partial-sum beat is present.
- `in_ready`  out  1  — block accepts a beat.
- `in_psum[2:0]`  in  20 signed each  — three row partial sums.
- `out_valid`  out  1  — a result is present.
- `out_ready`  in  1  — downstream accepts the result.
- `out_data`  out  `HWORD` signed  — saturated pixel result.
- `busy`  out  1  — state is not IDLE.
- `done`  out  1  — one-cycle pulse at job end.

## Operation
- FSM states: IDLE, ACCUM, OUTPUT, FINISH.
- **IDLE:** on `cfg_start`, latch every `cfg_*` field.
  - If `cfg_num_pix`==0, go to FINISH.
  - Otherwise load acc ← sign-extended bias, ch_cnt ← 0, pix_cnt ← 0, and go to ACCUM.
- **ACCUM:** `in_ready`=1. On each handshake (`in_valid`&`in_ready`):
  - acc ← acc + sext(in_psum[0]+in_psum[1]+in_psum[2]); the three-way sum is 23-bit, the accumulate is ACC_W-bit with no intermediate saturation.
  - ch_cnt increments.
  - On the beat where ch_cnt == latched num_ch: register the final value into `out_data` and go to OUTPUT.
- **Final value:** ACC_W sum saturated to [-32768, 32767]; then, if relu is set and the value is negative, 0.
- **OUTPUT:** `out_valid`=1; `out_data` holds stable until `out_ready`. On that handshake:
  - pix_cnt increments.
  - If pix_cnt+1 == num_pix, go to FINISH.
  - Otherwise reload acc ← bias, ch_cnt ← 0, and return to ACCUM.
- **FINISH:** `done`=1 for exactly one cycle, then IDLE.
- Latched config is immune to `cfg_*` changes during a job; `cfg_start` outside IDLE is ignored.
- Worst-case magnitude 256·3·2^19 < 2^31, so ACC_W=32 never wraps.

## Timing
- **Reset values:** state IDLE; `in_ready`, `out_valid`, `busy`, `done` = 0; `out_data`=0; counters and acc = 0.
- **Reset mid-job:** immediately IDLE with the values above; any pending result is discarded.
- `busy` rises the cycle after accepted `cfg_start` and falls the cycle after FINISH.
- `in_ready` is a registered state decode: high in every ACCUM cycle, low in all other states (no combinational path from `out_ready`).
- **Latency:** `out_valid` rises the cycle after the last channel beat is accepted.
- **Throughput:** one beat per cycle in ACCUM, plus ≥1 OUTPUT cycle per pixel; peak rate is N+1 beats plus 1 cycle per pixel.
- `out_ready` held high: OUTPUT lasts 1 cycle, and ACCUM resumes (or FINISH follows) on the next cycle.
- `in_valid` low in ACCUM: acc and counters hold.
- `done` asserts the cycle after the final output handshake; for num_pix=0 it asserts 1 cycle after start (start → FINISH → IDLE).

## Structure
- Shared DLA package holds:
  - state enum `psum_state_e`;
  - constants `HW_MAX`=32767 and `HW_MIN`=-32768;
  - `PSUM_W`=20.
- Half-word from the common `HWORD` define.
- One sub-module, `psum_sat_relu`: combinational ACC_W → `HWORD` saturation plus ReLU. The FSM, counters and accumulator stay in the top.

## Test plan
- **Basic accumulate:** num_ch=2 (3 channels), num_pix=1, bias=10, relu=0; beats {1,2,3},{4,5,6},{-1,0,0}, out_ready=1 → `out_data`=30 the cycle after the third beat; `done` the cycle after the output handshake.
- **Saturation:** num_ch=1, bias=0; beats {200000,200000,200000}×2 → 32767. With bias=-32768 and beats {-300000,0,0}×2 → -32768.
- **ReLU:** bias=-5, num_ch=0, relu=1, beat {1,1,1} → 0. Same with relu=0 → -2.
- **Backpressure and bubbles:** num_pix=2; hold `out_ready`=0 for 5 cycles → `out_data` stable, `in_ready`=0 throughout. Random `in_valid` gaps do not change either sum, and acc reloads to bias for pixel 2.
- **Empty job and ignored start:** num_pix=0 → `done` 1 cycle after start, no `out_valid`. Pulsing `cfg_start` with new config mid-job → no effect on results.
- **Async reset mid-OUTPUT:** all outputs go to 0 without a clock edge; a new job after release produces correct results.

Source files
------------

// File: rtl/dla_psum_accum_ctrl_pkg.sv
// Shared DLA definitions for the partial-sum accumulation sequencer:
// FSM state encoding, row partial-sum width and half-word saturation limits.
`ifndef HWORD
`define HWORD 16
`endif

package dla_psum_accum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2,
    ST_FINISH = 2'd3
  } psum_state_e;

  localparam int PSUM_W    = 20;
  // Three PSUM_W operands summed; one guard bit more than strictly needed.
  localparam int ROW_SUM_W = PSUM_W + 3;
  localparam int HW_MAX    = 32767;
  localparam int HW_MIN    = -32768;

endpackage

// File: rtl/psum_sat_relu.sv
// Combinational clamp of the wide accumulator into a signed half-word,
// followed by optional ReLU on the clamped value.
`ifndef HWORD
`define HWORD 16
`endif

module psum_sat_relu
  import dla_psum_accum_ctrl_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic                      relu,
  output logic signed [`HWORD-1:0]  res
);

  localparam int HW = `HWORD;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(HW_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(HW_MIN);

  always_comb begin
    res = acc[HW-1:0];
    if (acc > SAT_HI) begin
      res = HW'(HW_MAX);
    end else if (acc < SAT_LO) begin
      res = HW'(HW_MIN);
    end
    if (relu && res[HW-1]) begin
      res = '0;
    end
  end

endmodule

// File: rtl/dla_psum_accum_ctrl.sv
// Sums three row partial sums per beat, accumulates them over the programmed
// channel count from a per-job bias, and emits one saturated result per pixel.
`ifndef HWORD
`define HWORD 16
`endif

module dla_psum_accum_ctrl
  import dla_psum_accum_ctrl_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int PIX_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [CH_W-1:0]          cfg_num_ch,
  input  logic [PIX_W-1:0]         cfg_num_pix,
  input  logic signed [`HWORD-1:0] cfg_bias,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PSUM_W-1:0] in_psum [2:0],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [`HWORD-1:0] out_data,
  output logic                     busy,
  output logic                     done,
  output psum_state_e              dbg_state
);

  localparam int HW = `HWORD;

  // Handshakes: a beat moves on a rising edge where in_valid && in_ready;
  // a result moves on a rising edge where out_valid && out_ready. Both
  // ready/valid outputs are pure decodes of the state register.

  psum_state_e state, state_nx;

  logic [CH_W-1:0]         ch_cnt, num_ch_q;
  logic [PIX_W-1:0]        pix_cnt, num_pix_q;
  logic signed [HW-1:0]    bias_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc;

  logic signed [ROW_SUM_W-1:0] row_sum;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [ACC_W-1:0]     cfg_bias_ext, bias_q_ext;
  logic signed [HW-1:0]        sat_res;
  logic                        ch_last, pix_last;

  always_comb begin
    row_sum = {{(ROW_SUM_W-PSUM_W){in_psum[0][PSUM_W-1]}}, in_psum[0]}
            + {{(ROW_SUM_W-PSUM_W){in_psum[1][PSUM_W-1]}}, in_psum[1]}
            + {{(ROW_SUM_W-PSUM_W){in_psum[2][PSUM_W-1]}}, in_psum[2]};
  end

  assign acc_sum      = acc + {{(ACC_W-ROW_SUM_W){row_sum[ROW_SUM_W-1]}}, row_sum};
  assign cfg_bias_ext = {{(ACC_W-HW){cfg_bias[HW-1]}}, cfg_bias};
  assign bias_q_ext   = {{(ACC_W-HW){bias_q[HW-1]}}, bias_q};
  assign ch_last      = (ch_cnt == num_ch_q);
  assign pix_last     = ((pix_cnt + PIX_W'(1)) == num_pix_q);

  // Saturate the value that includes the current beat, so the final result
  // is registered on the same edge that accepts the last channel.
  psum_sat_relu #(.ACC_W(ACC_W)) u_sat (
    .acc  (acc_sum),
    .relu (relu_q),
    .res  (sat_res)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (cfg_start) state_nx = (cfg_num_pix == '0) ? ST_FINISH : ST_ACCUM;
      ST_ACCUM:  if (in_valid && ch_last) state_nx = ST_OUTPUT;
      ST_OUTPUT: if (out_ready) state_nx = pix_last ? ST_FINISH : ST_ACCUM;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      num_ch_q  <= '0;
      num_pix_q <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            num_ch_q  <= cfg_num_ch;
            num_pix_q <= cfg_num_pix;
            bias_q    <= cfg_bias;
            relu_q    <= cfg_relu;
            if (cfg_num_pix != '0) begin
              acc     <= cfg_bias_ext;
              ch_cnt  <= '0;
              pix_cnt <= '0;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc    <= acc_sum;
            ch_cnt <= ch_cnt + CH_W'(1);
            if (ch_last) out_data <= sat_res;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            if (!pix_last) begin
              acc    <= bias_q_ext;
              ch_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_OUTPUT);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign dbg_state = state;

endmodule

// File: tb/tb_dla_psum_accum_ctrl.sv
// Scoreboard bench for dla_psum_accum_ctrl: jobs are built from beat queues,
// expected pixels come from plain-arithmetic sums, a monitor checks outputs.
module tb_dla_psum_accum_ctrl;
  import dla_psum_accum_ctrl_pkg::*;

  localparam int CH_W  = 8;
  localparam int PIX_W = 16;
  localparam int ACC_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_start;
  logic [CH_W-1:0]          cfg_num_ch;
  logic [PIX_W-1:0]         cfg_num_pix;
  logic signed [15:0]       cfg_bias;
  logic                     cfg_relu;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [19:0]       in_psum [2:0];
  logic                     out_valid;
  logic                     out_ready;
  logic signed [15:0]       out_data;
  logic                     busy;
  logic                     done;
  psum_state_e              dbg_state;

  dla_psum_accum_ctrl #(.CH_W(CH_W), .PIX_W(PIX_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_num_ch  (cfg_num_ch),
    .cfg_num_pix (cfg_num_pix),
    .cfg_bias    (cfg_bias),
    .cfg_relu    (cfg_relu),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_psum     (in_psum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0]        exp_q[$];
  bit                 last_q[$];
  bit                 done_due = 1'b0;
  int                 bp_pct = 0;
  logic signed [19:0] bq0[$], bq1[$], bq2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bias plus every channel's three row sums, then clamp and ReLU.
  function automatic logic [15:0] ref_pixel(input longint s_in, input bit relu);
    longint s;
    s = s_in;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) >= bp_pct);
    end
  end

  task automatic add_beat(input int a, input int b, input int c);
    bq0.push_back(20'(a));
    bq1.push_back(20'(b));
    bq2.push_back(20'(c));
  endtask

  task automatic add_rand_beats(input int n, input bit big);
    for (int i = 0; i < n; i++) begin
      if (big) add_beat(int'($urandom), int'($urandom), int'($urandom));
      else add_beat(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                    int'($urandom_range(0, 4000)) - 2000);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("job_returns_idle", busy, 1'b0);
  endtask

  task automatic run_job(input int nch, input int npix, input int bias, input bit relu,
                         input int gap_pct, input bit mid_start);
    int total, k, guard;
    bit hs, lat_pending;
    longint s;
    total = (nch + 1) * npix;
    k = 0;
    for (int p = 0; p < npix; p++) begin
      s = longint'(bias);
      for (int c = 0; c <= nch; c++) begin
        s += longint'(bq0[k]) + longint'(bq1[k]) + longint'(bq2[k]);
        k++;
      end
      exp_q.push_back(ref_pixel(s, relu));
      last_q.push_back(p == npix - 1);
    end

    wait_idle();
    cfg_num_ch  = CH_W'(nch);
    cfg_num_pix = PIX_W'(npix);
    cfg_bias    = 16'(bias);
    cfg_relu    = relu;
    cfg_start   = 1'b1;
    @(posedge clk);
    #1;
    cfg_start   = 1'b0;
    cfg_num_ch  = CH_W'($urandom);
    cfg_num_pix = PIX_W'($urandom);
    cfg_bias    = 16'($urandom);
    cfg_relu    = 1'($urandom);
    if (npix == 0) done_due = 1'b1;

    k = 0;
    guard = 0;
    lat_pending = 1'b0;
    while (k < total && guard < 5000) begin
      in_valid   = ($urandom_range(0, 99) >= gap_pct);
      in_psum[0] = bq0[k];
      in_psum[1] = bq1[k];
      in_psum[2] = bq2[k];
      if (mid_start) cfg_start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (lat_pending) begin
        check("out_valid_after_last_beat", out_valid, 1'b1);
        lat_pending = 1'b0;
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        lat_pending = ((k % (nch + 1)) == nch);
        k++;
      end
      guard++;
    end
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    if (k < total) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: accepted %0d required %0d", k, total);
    end
    if (lat_pending) begin
      @(negedge clk);
      check("out_valid_after_last_beat", out_valid, 1'b1);
    end
    wait_idle();
    check("exp_queue_drained", exp_q.size(), 0);
    bq0.delete();
    bq1.delete();
    bq2.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("done_pulse", done, done_due);
        done_due = 1'b0;
        if (out_valid) begin
          check("in_ready_low_in_output", in_ready, 1'b0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out_valid: got data %0h expected no result", out_data);
          end else begin
            check("out_data", $unsigned(out_data), exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              if (last_q.pop_front()) done_due = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_num_ch = '0;
    cfg_num_pix = '0;
    cfg_bias = '0;
    cfg_relu = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) in_psum[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_out_data", $unsigned(out_data), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Basic accumulate: 10 + 6 + 15 - 1 = 30
    bp_pct = 0;
    add_beat(1, 2, 3);
    add_beat(4, 5, 6);
    add_beat(-1, 0, 0);
    run_job(2, 1, 10, 1'b0, 0, 1'b0);

    // Saturation high and low
    add_beat(200000, 200000, 200000);
    add_beat(200000, 200000, 200000);
    run_job(1, 1, 0, 1'b0, 0, 1'b0);
    add_beat(-300000, 0, 0);
    add_beat(-300000, 0, 0);
    run_job(1, 1, -32768, 1'b0, 0, 1'b0);

    // ReLU on and off
    add_beat(1, 1, 1);
    run_job(0, 1, -5, 1'b1, 0, 1'b0);
    add_beat(1, 1, 1);
    run_job(0, 1, -5, 1'b0, 0, 1'b0);

    // Backpressure with input bubbles over two pixels
    add_rand_beats(8, 1'b0);
    bp_pct = 100;
    fork
      run_job(3, 2, -1234, 1'b0, 40, 1'b0);
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!out_valid && g < 1000);
        repeat (5) begin
          @(negedge clk);
          check("bp_out_valid_held", out_valid, 1'b1);
        end
        bp_pct = 0;
      end
    join

    // Empty job, then a job with stray starts and new config mid-job
    run_job(0, 0, 0, 1'b0, 0, 1'b0);
    add_rand_beats(15, 1'b0);
    run_job(4, 3, 500, 1'b0, 20, 1'b1);

    // Asynchronous reset while a result waits in OUTPUT
    bp_pct = 100;
    wait_idle();
    add_beat(100, 20, 3);
    exp_q.push_back(ref_pixel(7 + 123, 1'b0));
    last_q.push_back(1'b0);
    cfg_num_ch = '0;
    cfg_num_pix = PIX_W'(3);
    cfg_bias = 16'sd7;
    cfg_relu = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    in_valid = 1'b1;
    in_psum[0] = bq0[0];
    in_psum[1] = bq1[0];
    in_psum[2] = bq2[0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_out_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_out_data", $unsigned(out_data), 0);
    exp_q.delete();
    last_q.delete();
    done_due = 1'b0;
    bq0.delete();
    bq1.delete();
    bq2.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    bp_pct = 0;
    add_rand_beats(6, 1'b0);
    run_job(2, 2, 42, 1'b1, 10, 1'b0);

    // Randomized jobs, including one with the full 256-channel depth
    for (int j = 0; j < 12; j++) begin
      int nch, npix;
      bit big;
      nch  = $urandom_range(0, 15);
      npix = $urandom_range(1, 5);
      big  = 1'($urandom);
      add_rand_beats((nch + 1) * npix, big);
      bp_pct = $urandom_range(0, 60);
      run_job(nch, npix, int'($urandom_range(0, 65535)) - 32768, 1'($urandom),
              $urandom_range(0, 50), 1'($urandom));
    end
    bp_pct = 0;
    add_rand_beats(256, 1'b1);
    run_job(255, 1, -32768, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
